// File: rtl/i2c_init_sequencer.sv
// Script-driven bring-up master for the I2C_v2 command port: plays WRITE/WAIT/DELAY/END
// entries from a ROM, then hands the port to the CPU (PASS) with combinational pass-through.
module i2c_init_sequencer #(
    parameter int SCRIPT_AW  = 8,
    parameter bit AUTOSTART  = 1'b1,
    parameter int POLL_LIMIT = 4096
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [SCRIPT_AW-1:0] o_rom_address,
    input  logic [31:0]          i_rom_data,
    input  logic                 i_request,
    input  logic                 i_rw,
    input  logic [1:0]           i_address,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_rdata,
    output logic                 o_ready,
    output logic                 o_i2c_request,
    output logic                 o_i2c_rw,
    output logic [1:0]           o_i2c_address,
    output logic [31:0]          o_i2c_wdata,
    input  logic [31:0]          i_i2c_rdata,
    input  logic                 i_i2c_ready
);

    localparam int PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_FETCH_WAIT, S_DECODE, S_XFER,
        S_RELEASE, S_DELAY, S_NEXT, S_DONE, S_PASS
    } state_t;

    state_t               state_q;
    logic [SCRIPT_AW-1:0] pc_q;
    logic [31:0]          entry_q;
    logic [23:0]          delay_q;
    logic [PW-1:0]        poll_q;
    logic                 req_q;
    logic                 rw_q;
    logic [31:0]          wdata_q;
    logic                 stat_ok_q;
    logic                 done_q;
    logic                 error_q;
    logic                 pend_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            entry_q   <= '0;
            delay_q   <= '0;
            poll_q    <= '0;
            req_q     <= 1'b0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            stat_ok_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (AUTOSTART || i_start) begin
                        pc_q    <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH:      state_q <= S_FETCH_WAIT;
                S_FETCH_WAIT: begin
                    entry_q <= i_rom_data;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    case (entry_q[1:0])
                        2'd0: state_q <= S_DONE;
                        2'd1: begin
                            poll_q  <= '0;
                            rw_q    <= 1'b0;
                            wdata_q <= '0;
                            state_q <= S_XFER;
                        end
                        2'd2: begin
                            rw_q    <= 1'b1;
                            wdata_q <= entry_q;
                            state_q <= S_XFER;
                        end
                        default: begin
                            delay_q <= entry_q[31:8];
                            state_q <= (entry_q[31:8] == 24'd0) ? S_NEXT : S_DELAY;
                        end
                    endcase
                end
                // Ready must be seen low before requesting, so a stale ready from a
                // previous owner of the port is never mistaken for an acknowledge.
                S_XFER: begin
                    if (!req_q) begin
                        if (!i_i2c_ready) req_q <= 1'b1;
                    end else if (i_i2c_ready) begin
                        req_q     <= 1'b0;
                        stat_ok_q <= !i_i2c_rdata[4] && i_i2c_rdata[3];
                        state_q   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!i_i2c_ready) begin
                        if (rw_q || stat_ok_q) begin
                            state_q <= S_NEXT;
                        end else if (poll_q + 1'b1 == PW'(POLL_LIMIT)) begin
                            poll_q  <= poll_q + 1'b1;
                            error_q <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            poll_q  <= poll_q + 1'b1;
                            state_q <= S_XFER;
                        end
                    end
                end
                S_DELAY: begin
                    delay_q <= delay_q - 24'd1;
                    if (delay_q == 24'd1) state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (pc_q == {SCRIPT_AW{1'b1}}) begin
                        state_q <= S_DONE;
                    end else begin
                        pc_q    <= pc_q + 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_PASS;
                end
                S_PASS: begin
                    // A restart must not cut off a CPU transfer mid-handshake.
                    if (i_start || pend_q) begin
                        if (i_request) begin
                            pend_q <= 1'b1;
                        end else begin
                            pend_q  <= 1'b0;
                            pc_q    <= '0;
                            done_q  <= 1'b0;
                            error_q <= 1'b0;
                            state_q <= S_FETCH;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic pass;
    assign pass = (state_q == S_PASS);

    assign o_busy        = !(state_q == S_IDLE || pass);
    assign o_done        = done_q;
    assign o_error       = error_q;
    assign o_rom_address = pc_q;

    assign o_i2c_request = pass ? i_request : req_q;
    assign o_i2c_rw      = pass ? i_rw      : rw_q;
    assign o_i2c_address = pass ? i_address : 2'd0;
    assign o_i2c_wdata   = pass ? i_wdata   : wdata_q;
    assign o_rdata       = pass ? i_i2c_rdata : 32'd0;
    assign o_ready       = pass && i_i2c_ready;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: ROM + I2C_v2 slave models, write scoreboard, vector table
// for script runs and hand-written sequences for delay timing, queue-full, CPU stall and reset.
module tb_i2c_init_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_start = 1'b0;
    logic        o_busy, o_done, o_error;
    logic [4:0]  o_rom_address;
    logic [31:0] i_rom_data = '0;
    logic        i_request = 1'b0, i_rw = 1'b0;
    logic [1:0]  i_address = '0;
    logic [31:0] i_wdata = '0;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_i2c_request, o_i2c_rw;
    logic [1:0]  o_i2c_address;
    logic [31:0] o_i2c_wdata;
    logic [31:0] i2c_rdata = '0;
    logic        i2c_rdy = 1'b0;

    always #5 clk = ~clk;

    i2c_init_sequencer #(.SCRIPT_AW(5), .AUTOSTART(1'b1), .POLL_LIMIT(64)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_rom_address(o_rom_address), .i_rom_data(i_rom_data),
        .i_request(i_request), .i_rw(i_rw), .i_address(i_address), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_ready(o_ready),
        .o_i2c_request(o_i2c_request), .o_i2c_rw(o_i2c_rw),
        .o_i2c_address(o_i2c_address), .o_i2c_wdata(o_i2c_wdata),
        .i_i2c_rdata(i2c_rdata), .i_i2c_ready(i2c_rdy)
    );

    // Stimulus-side state (written only by the main initial block)
    logic [31:0] rom [0:31];
    int          busy_polls = 0;
    bit          stuck = 1'b0;
    bit          qfull = 1'b0;
    bit          qrand = 1'b0;
    int          poll_base = 0;

    // Model-side state (written only by the model process)
    logic [31:0] rom_stage = '0;
    logic [31:0] got_mem [0:1023];
    int          got_cyc [0:1023];
    int          got_n = 0;
    int          polls_tot = 0;
    int          viol = 0;
    int          cyc = 0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_wdata = '0;

    int          checks = 0;
    int          errors = 0;
    int          rd = 0;
    logic [31:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] busy_pat(int p);
        case (p % 3)
            0:       return 32'h0000_0010;
            1:       return 32'h0000_0000;
            default: return 32'h0000_0018;
        endcase
    endfunction

    // ROM (1-cycle latency) and I2C_v2 slave, evaluated on the falling edge.
    always @(negedge clk) begin
        bit full_eff;
        int p;
        i_rom_data = rom_stage;
        rom_stage  = rom[o_rom_address];
        full_eff   = qfull || (qrand && $urandom_range(0, 3) != 0);
        if (rst_n && o_busy && prev_req &&
            ((!o_i2c_request && !i2c_rdy) || (o_i2c_request && o_i2c_wdata != prev_wdata)))
            viol++;
        prev_req   = o_i2c_request;
        prev_wdata = o_i2c_wdata;
        if (!o_i2c_request) begin
            i2c_rdy = 1'b0;
        end else if (!i2c_rdy && (!o_i2c_rw || !full_eff)) begin
            i2c_rdy = 1'b1;
            if (o_i2c_rw) begin
                if (o_busy) begin
                    if (o_i2c_address != 2'd0) viol++;
                    got_mem[got_n % 1024] = o_i2c_wdata;
                    got_cyc[got_n % 1024] = cyc;
                    got_n++;
                end
            end else if (o_i2c_address == 2'd0) begin
                p = polls_tot - poll_base;
                i2c_rdata = (stuck || p < busy_polls) ? busy_pat(p) : 32'hFFFF_FFE8;
                if (o_busy) polls_tot++;
            end else begin
                i2c_rdata = 32'hA5A5_0000 | 32'(o_i2c_address);
            end
        end
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drain(string nm);
        logic [31:0] e;
        while (rd < got_n) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s_dup: got write %h expected none", nm, got_mem[rd % 1024]);
            end else begin
                e = exp_q.pop_front();
                if (got_mem[rd % 1024] !== e) begin
                    errors++;
                    $display("FAIL %s_wr: got %h expected %h", nm, got_mem[rd % 1024], e);
                end
            end
            rd++;
        end
        check({nm, "_lost"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic kick();
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
    endtask

    task automatic wait_done(string nm, int maxc);
        int k = 0;
        while (!(o_done === 1'b1 && o_busy === 1'b0) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_timeout"}, 32'(k >= maxc), 0);
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 32; a++) rom[a] = 32'h0;
    endtask

    typedef struct {
        logic [31:0] e0, e1, e2, e3;
        int          busy;
        bit          stk;
        int          polls;
        bit          err;
    } vec_t;

    function automatic vec_t mk(logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                                logic [31:0] e3, int busy, bit stk, int polls, bit err);
        vec_t v;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
        v.busy = busy; v.stk = stk; v.polls = polls; v.err = err;
        return v;
    endfunction

    localparam int NV = 6;
    vec_t vt [NV];

    initial begin
        int base, gap100, gap0, stall, k;
        logic [31:0] ent [4];

        vt[0] = mk(32'h5A10_3402, 32'h0, 32'h0, 32'h0,  0, 1'b0,  0, 1'b0);
        vt[1] = mk(32'h0000_0001, 32'h0, 32'h0, 32'h0, 50, 1'b0, 51, 1'b0);
        vt[2] = mk(32'h0000_0001, 32'h1122_3302, 32'h0, 32'h0, 0, 1'b1, 64, 1'b1);
        vt[3] = mk(32'hAB00_0002, 32'h0000_0303, 32'h0000_0001, 32'hCD00_0002, 2, 1'b0, 3, 1'b0);
        vt[4] = mk(32'h0000_0003, 32'h7766_5502, 32'h0, 32'h0,  0, 1'b0,  0, 1'b0);
        vt[5] = mk(32'h0000_0001, 32'h0F0F_0F02, 32'h0, 32'h0,  0, 1'b0,  1, 1'b0);

        // Reset state, then autostart of {WRITE 0x5A103402, END}
        clear_rom();
        rom[0] = 32'h5A10_3402;
        exp_q.push_back(32'h5A10_3402);
        #1 rst_n = 1'b0;
        #3;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_i2c_req", o_i2c_request, 0);
        check("rst_ready", o_ready, 0);
        check("rst_rom_addr", o_rom_address, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done("auto", 200);
        check("auto_err", o_error, 0);
        drain("auto");

        for (int i = 0; i < NV; i++) begin
            clear_rom();
            rom[0] = vt[i].e0; rom[1] = vt[i].e1; rom[2] = vt[i].e2; rom[3] = vt[i].e3;
            ent[0] = vt[i].e0; ent[1] = vt[i].e1; ent[2] = vt[i].e2; ent[3] = vt[i].e3;
            busy_polls = vt[i].busy;
            stuck      = vt[i].stk;
            poll_base  = polls_tot;
            for (int j = 0; j < 4; j++) begin
                if (ent[j][1:0] == 2'd0) break;
                if (ent[j][1:0] == 2'd1 && vt[i].err) break;
                if (ent[j][1:0] == 2'd2) exp_q.push_back(ent[j]);
            end
            kick();
            wait_done($sformatf("vec%0d", i), 3000);
            check($sformatf("vec%0d_err", i), o_error, 32'(vt[i].err));
            check($sformatf("vec%0d_polls", i), polls_tot - poll_base, vt[i].polls);
            drain($sformatf("vec%0d", i));
        end
        stuck = 1'b0;
        busy_polls = 0;

        // DELAY 100 versus DELAY 0 between two writes: gaps differ by exactly 100 cycles
        clear_rom();
        rom[0] = 32'h0000_0102; rom[1] = 32'h0000_6403; rom[2] = 32'h0000_0202;
        exp_q.push_back(32'h0000_0102); exp_q.push_back(32'h0000_0202);
        base = got_n;
        kick();
        wait_done("dly100", 500);
        gap100 = got_cyc[(base + 1) % 1024] - got_cyc[base % 1024];
        drain("dly100");
        rom[1] = 32'h0000_0003;
        exp_q.push_back(32'h0000_0102); exp_q.push_back(32'h0000_0202);
        base = got_n;
        kick();
        wait_done("dly0", 500);
        gap0 = got_cyc[(base + 1) % 1024] - got_cyc[base % 1024];
        drain("dly0");
        check("dly_gap", gap100 - gap0, 100);

        // Whole ROM of WRITEs (no END) under a randomly full command queue
        for (int a = 0; a < 32; a++) begin
            rom[a] = 32'h00C0_0002 | (32'(a) << 24);
            exp_q.push_back(rom[a]);
        end
        qrand = 1'b1;
        kick();
        wait_done("fullrom", 20000);
        qrand = 1'b0;
        check("fullrom_err", o_error, 0);
        drain("fullrom");
        check("fullrom_proto", viol, 0);

        // PASS read, start held pending behind the CPU request, then CPU stall while busy
        clear_rom();
        rom[0] = 32'h0000_C803;
        @(negedge clk); i_request = 1'b1; i_rw = 1'b0; i_address = 2'd2;
        k = 0;
        while (!o_ready && k < 10) begin @(negedge clk); k++; end
        check("cpu_rdy", o_ready, 1);
        check("cpu_rdata2", o_rdata, 32'hA5A5_0002);
        i_start = 1'b1; @(negedge clk); i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("pend_busy", o_busy, 0);
        check("pend_done", o_done, 1);
        i_request = 1'b0;
        k = 0;
        while (!o_busy && k < 5) begin @(negedge clk); k++; end
        check("pend_go", o_busy, 1);
        check("pend_done_clr", o_done, 0);
        @(negedge clk); i_request = 1'b1; i_rw = 1'b0; i_address = 2'd1;
        stall = 0;
        repeat (60) begin
            @(negedge clk);
            if (o_ready || o_i2c_request) stall++;
        end
        check("cpu_stall", stall, 0);
        wait_done("cpu_pass", 400);
        k = 0;
        while (!o_ready && k < 10) begin @(negedge clk); k++; end
        check("cpu_rdy1", o_ready, 1);
        check("cpu_rdata1", o_rdata, 32'hA5A5_0001);
        i_request = 1'b0;
        repeat (3) @(negedge clk);

        // Reset while a WRITE is held off by a full queue; rerun starts at entry 0
        clear_rom();
        rom[0] = 32'hDEAD_0002;
        qfull = 1'b1;
        base = got_n;
        kick();
        k = 0;
        while (!o_i2c_request && k < 20) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        check("xfer_held", o_i2c_request, 1);
        check("xfer_no_accept", got_n - base, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req_drop", o_i2c_request, 0);
        check("arst_busy", o_busy, 0);
        exp_q.delete();
        rom[0] = 32'h600D_0002;
        exp_q.push_back(32'h600D_0002);
        qfull = 1'b0;
        @(negedge clk);
        check("arst_pc", o_rom_address, 0);
        rst_n = 1'b1;
        wait_done("rerun", 300);
        check("rerun_err", o_error, 0);
        drain("rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
